// File: rtl/sop_pkg.sv
// sop_pkg: default reset table and literal-match helper shared by sop_pipe_eval
package sop_pkg;

    localparam int          MAX_IN       = 32;
    localparam logic [19:0] DEF_CARE_5x4 = 20'h61A67;
    localparam logic [19:0] DEF_POL_5x4  = 20'h20261;
    localparam logic [3:0]  DEF_EN_4     = 4'hF;

    // Uncared bits are zero-extended so they always pass the reduction.
    function automatic logic lit_match(
        input logic [MAX_IN-1:0] x,
        input logic [MAX_IN-1:0] care,
        input logic [MAX_IN-1:0] pol
    );
        return &(~care | ~(x ^ pol));
    endfunction

endpackage

// File: rtl/sop_term_match.sv
// sop_term_match: one product term with its config registers and registered hit
module sop_term_match
    import sop_pkg::*;
#(
    parameter int              N_IN       = 5,
    parameter logic [N_IN-1:0] RESET_CARE = '0,
    parameter logic [N_IN-1:0] RESET_POL  = '0,
    parameter logic            RESET_EN   = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv,
    input  logic            we,
    input  logic [N_IN-1:0] cfg_care,
    input  logic [N_IN-1:0] cfg_pol,
    input  logic            cfg_en,
    input  logic [N_IN-1:0] x,
    output logic            hit
);

    logic [N_IN-1:0] care;
    logic [N_IN-1:0] pol;
    logic            en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            care <= RESET_CARE;
            pol  <= RESET_POL;
            en   <= RESET_EN;
        end else if (we) begin
            care <= cfg_care;
            pol  <= cfg_pol;
            en   <= cfg_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit <= 1'b0;
        else if (adv)
            hit <= en && lit_match(MAX_IN'(x), MAX_IN'(care), MAX_IN'(pol));
    end

endmodule

// File: rtl/sop_pipe_eval.sv
// sop_pipe_eval: 3-stage pipelined programmable sum-of-products with valid/ready flow control
module sop_pipe_eval
    import sop_pkg::*;
#(
    parameter int                      N_IN       = 5,
    parameter int                      N_TERMS    = 4,
    parameter logic [N_TERMS*N_IN-1:0] RESET_CARE = DEF_CARE_5x4,
    parameter logic [N_TERMS*N_IN-1:0] RESET_POL  = DEF_POL_5x4,
    parameter logic [N_TERMS-1:0]      RESET_EN   = DEF_EN_4
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [N_IN-1:0]                                 x,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic                                            y,
    output logic [N_TERMS-1:0]                              hits,
    input  logic                                            cfg_we,
    input  logic [(N_TERMS > 1 ? $clog2(N_TERMS) : 1)-1:0]  cfg_idx,
    input  logic [N_IN-1:0]                                 cfg_care,
    input  logic [N_IN-1:0]                                 cfg_pol,
    input  logic                                            cfg_en,
    output logic                                            busy
);

    localparam int IW = N_TERMS > 1 ? $clog2(N_TERMS) : 1;

    logic               adv;
    logic               v1;
    logic               v2;
    logic               v3;
    logic [N_IN-1:0]    x1;
    logic [N_TERMS-1:0] hit2;

    assign adv       = !v3 || out_ready;
    assign in_ready  = adv && !cfg_we;
    assign out_valid = v3;
    assign busy      = v1 | v2 | v3;

    // Out-of-range indices match no generate slot, so such writes are dropped.
    for (genvar k = 0; k < N_TERMS; k++) begin : g_term
        sop_term_match #(
            .N_IN      (N_IN),
            .RESET_CARE(RESET_CARE[k*N_IN +: N_IN]),
            .RESET_POL (RESET_POL[k*N_IN +: N_IN]),
            .RESET_EN  (RESET_EN[k])
        ) u_term (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .we      (cfg_we && cfg_idx == IW'(k)),
            .cfg_care(cfg_care),
            .cfg_pol (cfg_pol),
            .cfg_en  (cfg_en),
            .x       (x1),
            .hit     (hit2[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            x1   <= '0;
            y    <= 1'b0;
            hits <= '0;
        end else if (adv) begin
            v1   <= in_valid && in_ready;
            x1   <= x;
            v2   <= v1;
            v3   <= v2;
            y    <= |hit2;
            hits <= hit2;
        end
    end

endmodule

// File: tb/tb_sop_pipe_eval.sv
// tb_sop_pipe_eval: directed and randomized checks of sop_pipe_eval against a table-driven model
module tb_sop_pipe_eval;
    import sop_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cfg_we = 1'b0;
    logic       cfg_en = 1'b0;
    logic [4:0] x = '0;
    logic [4:0] cfg_care = '0;
    logic [4:0] cfg_pol = '0;
    logic [1:0] cfg_idx = '0;
    logic       in_ready, out_valid, y, busy;
    logic [3:0] hits;

    logic       in_valid5 = 1'b0;
    logic       cfg_we5 = 1'b0;
    logic [2:0] cfg_idx5 = '0;
    logic       in_ready5, out_valid5, y5, busy5;
    logic [4:0] hits5;

    sop_pipe_eval dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .hits(hits),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
        .cfg_en(cfg_en), .busy(busy)
    );

    // Five-term variant so that out-of-range indices 5..7 are expressible.
    sop_pipe_eval #(
        .N_TERMS(5), .RESET_CARE({5'h00, DEF_CARE_5x4}),
        .RESET_POL({5'h00, DEF_POL_5x4}), .RESET_EN(5'h0F)
    ) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5), .x(x),
        .out_valid(out_valid5), .out_ready(out_ready), .y(y5), .hits(hits5),
        .cfg_we(cfg_we5), .cfg_idx(cfg_idx5), .cfg_care(cfg_care), .cfg_pol(cfg_pol),
        .cfg_en(cfg_en), .busy(busy5)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0, cyc = 0, last_pop = -10, run = 0;
    logic [4:0] m_care[4];
    logic [4:0] m_pol[4];
    logic [3:0] m_en;
    logic [3:0] expq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A term hits when the cared bits of x equal the cared bits of its polarity.
    function automatic logic [3:0] model_hits(input logic [4:0] xv);
        logic [3:0] h;
        for (int k = 0; k < 4; k++)
            h[k] = m_en[k] && ((xv & m_care[k]) == (m_pol[k] & m_care[k]));
        return h;
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 4; k++) begin
            m_care[k] = DEF_CARE_5x4[k*5 +: 5];
            m_pol[k]  = DEF_POL_5x4[k*5 +: 5];
        end
        m_en = 4'hF;
        expq.delete();
    endtask

    always @(posedge clk) if (rst_n) begin
        cyc++;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL pop_underflow: output consumed with no sample outstanding (t=%0t)", $time);
            end else
                void'(expq.pop_front());
            n_pop++;
            run = (cyc == last_pop + 1) ? run + 1 : 1;
            last_pop = cyc;
        end
        if (in_valid && in_ready) begin
            expq.push_back(model_hits(x));
            n_push++;
        end
        if (cfg_we) begin
            m_care[cfg_idx] = cfg_care;
            m_pol[cfg_idx]  = cfg_pol;
            m_en[cfg_idx]   = cfg_en;
        end
    end

    always @(negedge clk) if (rst_n) begin
        check("in_ready", in_ready, (!out_valid || out_ready) && !cfg_we);
        check("busy", busy, expq.size() != 0);
        if (out_valid) begin
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: out_valid=1 with no sample outstanding (t=%0t)", $time);
            end else
                check("out_y_hits", {y, hits}, {|expq[0], expq[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run1(input logic [4:0] xv, output logic [3:0] h, output logic yo);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = xv;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("latency", lat, 3);
        h  = hits;
        yo = y;
        step();
    endtask

    task automatic run5(input logic [4:0] xv, output logic [4:0] h, output logic yo);
        int lat;
        in_valid5 = 1'b1;
        x         = xv;
        step();
        in_valid5 = 1'b0;
        lat = 1;
        while (!out_valid5 && lat < 10) begin
            step();
            lat++;
        end
        check("latency5", lat, 3);
        h  = hits5;
        yo = y5;
        step();
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [4:0] care, input logic [4:0] pol, input logic en);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_care = care;
        cfg_pol  = pol;
        cfg_en   = en;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] h;
        logic [4:0] h5;
        logic [4:0] hold;
        logic       yo;
        logic [4:0] xs[4];
        int         p, pp, lat;
        xs = '{5'b00000, 5'b11111, 5'b00001, 5'b10101};
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 0);
        check("rst_hits", hits, 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", in_ready, 1);

        run1(5'b00001, h, yo);
        check("t1_hits", h, 4'b0101);
        check("t1_y", yo, 1);
        run1(5'b00100, h, yo);
        check("t2a_hits", h, 4'b1000);
        check("t2a_y", yo, 1);
        run1(5'b01110, h, yo);
        check("t2b_hits", h, 4'b0000);
        check("t2b_y", yo, 0);
        run1(5'b10011, h, yo);
        check("t2c_hits", h, 4'b0010);
        check("t2c_y", yo, 1);

        p = n_pop;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            x = 5'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (5) step();
        check("stream_count", n_pop - p, 8);
        check("stream_consecutive", run, 8);

        p = n_pop;
        pp = n_push;
        hold = '0;
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            x         = 5'($urandom);
            out_ready = !(i >= 6 && i < 11);
            if (i == 6) begin
                check("stall_valid", out_valid, 1);
                hold = {y, hits};
            end
            if (i > 6 && i < 11) begin
                check("stall_hold", {y, hits}, hold);
                check("stall_in_ready", in_ready, 0);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("stall_pushed", n_push - pp, 15);
        check("stall_no_loss", n_pop - p, n_push - pp);

        cfg_write(2'd2, 5'b00000, 5'b00000, 1'b1);
        run1(5'b11111, h, yo);
        check("t4_care0_hits", h, 4'b0110);
        check("t4_care0_y", yo, 1);
        cfg_write(2'd0, 5'b00111, 5'b00001, 1'b0);
        cfg_write(2'd1, 5'b10011, 5'b10011, 1'b0);
        cfg_write(2'd3, 5'b01100, 5'b00100, 1'b0);
        cfg_write(2'd2, 5'b00000, 5'b00000, 1'b0);
        foreach (xs[i]) begin
            run1(xs[i], h, yo);
            check("t4_alloff_hits", h, 4'b0000);
            check("t4_alloff_y", yo, 0);
        end

        run5(5'b01110, h5, yo);
        check("t4_5_before", {yo, h5}, 6'b0_00000);
        cfg_we5 = 1'b1;
        cfg_idx5 = 3'd5;
        cfg_care = '0;
        cfg_pol = '0;
        cfg_en = 1'b1;
        step();
        cfg_idx5 = 3'd7;
        step();
        cfg_we5 = 1'b0;
        run5(5'b01110, h5, yo);
        check("t4_5_oob_ignored", {yo, h5}, 6'b0_00000);
        cfg_we5 = 1'b1;
        cfg_idx5 = 3'd4;
        step();
        cfg_we5 = 1'b0;
        run5(5'b01110, h5, yo);
        check("t4_5_idx4_write", {yo, h5}, 6'b1_10000);

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x = 5'($urandom);
            step();
        end
        in_valid = 1'b0;
        check("t5_busy_before", busy, 1);
        #1;
        rst_n = 1'b0;
        reset_model();
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_y_hits", {y, hits}, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run1(5'b00001, h, yo);
        check("t5_default_hits", h, 4'b0101);
        check("t5_default_y", yo, 1);

        in_valid = 1'b1;
        x = 5'b11111;
        cfg_we = 1'b1;
        cfg_idx = 2'd0;
        cfg_care = '0;
        cfg_pol = '0;
        cfg_en = 1'b1;
        #1;
        check("t6_in_ready_we", in_ready, 0);
        step();
        cfg_we = 1'b0;
        #1;
        check("t6_in_ready_after", in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("t6_latency", lat, 3);
        check("t6_hits", hits, 4'b0011);
        check("t6_y", y, 1);
        step();

        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 49) begin
                in_valid = 1'b0;
                out_ready = 1'b1;
                for (int j = 0; j < 10 && busy; j++) step();
                check("rand_drain", busy, 0);
                cfg_write(2'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
            end
            in_valid  = $urandom_range(0, 2) != 0;
            x         = 5'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        check("final_empty", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
